// File: rtl/fpu_pkg.sv
// Shared types for the FPU compare path: op codes, operand class bits, canonical NaN.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fpu_pkg;

  // Operation codes for the compare/min/max unit; 5..7 are reserved.
  typedef enum logic [2:0] {
    OP_MIN = 3'd0,
    OP_MAX = 3'd1,
    OP_EQ  = 3'd2,
    OP_LT  = 3'd3,
    OP_LE  = 3'd4
  } cmp_op_e;

  // One-hot operand classification.
  typedef struct packed {
    logic zero;
    logic subnormal;
    logic normal;
    logic inf;
    logic qnan;
    logic snan;
  } fp_class_t;

  // Widest format the canonical NaN helper can build.
  localparam int MAX_FP_W = 64;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
  // Callers take the low 1+exp_w+man_w bits.
  function automatic logic [MAX_FP_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [MAX_FP_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies the magnitude field {exp, mantissa} of one operand into zero/sub/normal/inf/qNaN/sNaN.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module fp_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output fp_class_t              cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign exp_f    = mag[MAN_W +: EXP_W];
  assign man_f    = mag[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  // Decode the class; the sign does not affect classification so it is not an input.
  always_comb begin
    cls           = '0;
    cls.zero      = exp_zero & man_zero;
    cls.subnormal = exp_zero & ~man_zero;
    cls.normal    = ~exp_zero & ~exp_ones;
    cls.inf       = exp_ones & man_zero;
    cls.qnan      = exp_ones & man_f[MAN_W-1];
    cls.snan      = exp_ones & ~man_f[MAN_W-1] & ~man_zero;
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point EQ/LT/LE compare and MIN/MAX with NaN, signed-zero and NV semantics.
// Latency: PIPE_STAGES (1 or 2) cycles from accept to out_valid_o, one op per cycle.
// Backpressure: valid/ready; a stage advances when empty or when the stage after it advances.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W       = 8,
  parameter int MAN_W       = 23,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2:0]               op_i,
  input  logic [EXP_W+MAN_W:0]     operand_a_i,
  input  logic [EXP_W+MAN_W:0]     operand_b_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic                     cmp_o,
  output logic                     nv_o,
  output logic [TAG_W-1:0]         tag_o
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [MAX_FP_W-1:0] CNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]        CNAN      = CNAN_FULL[W-1:0];

  // Everything stage 1 learns about an operation.
  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    fp_class_t        cls_a;
    fp_class_t        cls_b;
    logic             mag_lt;
    logic             mag_eq;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]     result;
    logic             cmp;
    logic             nv;
    logic [TAG_W-1:0] tag;
  } res_t;

  fp_class_t cls_a;
  fp_class_t cls_b;
  s1_t       s1_in;
  logic      feed_vld;
  res_t      feed_res;
  logic      out_adv;
  logic      out_vld_q;
  res_t      out_q;

  fp_class_t unused_cls;
  assign unused_cls = '0;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .mag (operand_a_i[W-2:0]),
    .cls (cls_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .mag (operand_b_i[W-2:0]),
    .cls (cls_b)
  );

  // Stage 1 front end: classes plus unsigned magnitude ordering on {exp, mantissa}.
  always_comb begin
    s1_in        = '0;
    s1_in.op     = op_i;
    s1_in.tag    = tag_i;
    s1_in.a      = operand_a_i;
    s1_in.b      = operand_b_i;
    s1_in.cls_a  = cls_a;
    s1_in.cls_b  = cls_b;
    s1_in.mag_lt = operand_a_i[W-2:0] < operand_b_i[W-2:0];
    s1_in.mag_eq = operand_a_i[W-2:0] == operand_b_i[W-2:0];
  end

  // Result/flag selection from stage-1 information.
  function automatic res_t select_result(input s1_t s);
    res_t r;
    logic sa, sb, a_nan, b_nan, any_snan, ordered, both_zero, eq, lt, lt_mm;
    sa        = s.a[W-1];
    sb        = s.b[W-1];
    a_nan     = s.cls_a.qnan | s.cls_a.snan;
    b_nan     = s.cls_b.qnan | s.cls_b.snan;
    any_snan  = s.cls_a.snan | s.cls_b.snan;
    ordered   = (s.cls_a.zero | s.cls_a.subnormal | s.cls_a.normal | s.cls_a.inf) &
                (s.cls_b.zero | s.cls_b.subnormal | s.cls_b.normal | s.cls_b.inf);
    both_zero = s.cls_a.zero & s.cls_b.zero;
    // Zeros of either sign are equal; otherwise identical encodings are equal.
    eq        = both_zero | (s.mag_eq & (sa == sb));
    // Negative magnitudes order in reverse; mixed signs are decided by the sign alone.
    if (both_zero)     lt = 1'b0;
    else if (sa != sb) lt = sa;
    else if (!sa)      lt = s.mag_lt;
    else               lt = ~s.mag_lt & ~s.mag_eq;
    // Min/max additionally place -0 below +0.
    lt_mm = lt | (both_zero & sa & ~sb);

    r     = '0;
    r.tag = s.tag;
    case (s.op)
      OP_MIN, OP_MAX: begin
        r.nv = any_snan;
        if (a_nan && b_nan)  r.result = CNAN;
        else if (a_nan)      r.result = s.b;
        else if (b_nan)      r.result = s.a;
        else if (s.op == OP_MIN) r.result = lt_mm ? s.a : s.b;
        else                     r.result = lt_mm ? s.b : s.a;
      end
      OP_EQ: begin
        r.cmp = ordered & eq;
        r.nv  = any_snan;
      end
      OP_LT: begin
        r.cmp = ordered & lt;
        r.nv  = ~ordered;
      end
      OP_LE: begin
        r.cmp = ordered & (lt | eq);
        r.nv  = ~ordered;
      end
      default: ;
    endcase
    if (s.op == OP_EQ || s.op == OP_LT || s.op == OP_LE) begin
      r.result = {{(W-1){1'b0}}, r.cmp};
    end
    return r;
  endfunction

  assign out_adv = ~out_vld_q | out_ready_i;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      s1_t  s1_q;
      logic s1_vld;

      assign in_ready_o = ~s1_vld | out_adv;
      assign feed_vld   = s1_vld;
      assign feed_res   = select_result(s1_q);

      // Stage-1 register: takes a new op whenever it is empty or its content moves on.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          s1_vld <= 1'b0;
          s1_q   <= '0;
        end else if (in_ready_o) begin
          s1_vld <= in_valid_i;
          if (in_valid_i) s1_q <= s1_in;
        end
      end
    end else if (PIPE_STAGES == 1) begin : g_one
      assign in_ready_o = out_adv;
      assign feed_vld   = in_valid_i;
      assign feed_res   = select_result(s1_in);
    end else begin : g_bad
      $error("fcmp_pipe: PIPE_STAGES must be 1 or 2");
      assign in_ready_o = 1'b0;
      assign feed_vld   = 1'b0;
      assign feed_res   = '0;
    end
  endgenerate

  // Output register: loads when empty or consumed, otherwise holds everything stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (out_adv) begin
      out_vld_q <= feed_vld;
      if (feed_vld) out_q <= feed_res;
    end
  end

  assign out_valid_o = out_vld_q;
  assign result_o    = out_q.result;
  assign cmp_o       = out_q.cmp;
  assign nv_o        = out_q.nv;
  assign tag_o       = out_q.tag;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: single precision with 2 stages and half precision with 1 stage.
// Latency: checks 2-cycle and 1-cycle accept-to-valid on the two instances.
// Backpressure: random and scripted out_ready stalls with a queue-based scoreboard.
module tb_fcmp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Single-precision instance
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [2:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0, s_result;
  logic [3:0]  s_tag = '0, s_tag_o;
  logic        s_cmp, s_nv;

  // Half-precision instance
  logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
  logic [2:0]  h_op = '0;
  logic [15:0] h_a = '0, h_b = '0, h_result;
  logic [3:0]  h_tag = '0, h_tag_o;
  logic        h_cmp, h_nv;

  int n_checks = 0;
  int n_pass = 0;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(2), .TAG_W(4)) u_sp (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .op_i(s_op), .operand_a_i(s_a), .operand_b_i(s_b), .tag_i(s_tag),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .result_o(s_result), .cmp_o(s_cmp), .nv_o(s_nv), .tag_o(s_tag_o)
  );

  fcmp_pipe #(.EXP_W(5), .MAN_W(10), .PIPE_STAGES(1), .TAG_W(4)) u_hp (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(h_in_valid), .in_ready_o(h_in_ready),
    .op_i(h_op), .operand_a_i(h_a), .operand_b_i(h_b), .tag_i(h_tag),
    .out_valid_o(h_out_valid), .out_ready_i(h_out_ready),
    .result_o(h_result), .cmp_o(h_cmp), .nv_o(h_nv), .tag_o(h_tag_o)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        nv;
    logic [3:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        nv;
  } dir_t;

  // Reference: map each value to a signed integer key (negatives are -magnitude, so
  // +0 and -0 collide); min/max use 2*key + (positive) to put -0 below +0.
  function automatic logic [33:0] ref_cmp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int ew, input int mw);
    longint emax, mmask, fmask, ma, mb, ea, eb, fa, fb, ka, kb, xa, xb, cnan;
    bit sa, sb, na, nb, sna, snb, anyn, anys, c;
    logic [31:0] res;
    emax  = (longint'(1) << ew) - 1;
    mmask = (longint'(1) << mw) - 1;
    fmask = (longint'(1) << (ew + mw)) - 1;
    ma = longint'(a) & fmask;  mb = longint'(b) & fmask;
    sa = a[ew + mw];           sb = b[ew + mw];
    ea = (ma >> mw) & emax;    eb = (mb >> mw) & emax;
    fa = ma & mmask;           fb = mb & mmask;
    na = (ea == emax) && (fa != 0);
    nb = (eb == emax) && (fb != 0);
    sna = na && (((fa >> (mw - 1)) & 1) == 0);
    snb = nb && (((fb >> (mw - 1)) & 1) == 0);
    anyn = na || nb;
    anys = sna || snb;
    ka = sa ? -ma : ma;        kb = sb ? -mb : mb;
    xa = 2 * ka + (sa ? 0 : 1); xb = 2 * kb + (sb ? 0 : 1);
    cnan = (emax << mw) | (longint'(1) << (mw - 1));
    res = '0; c = 0;
    case (op)
      3'd0, 3'd1: begin
        if (na && nb)      res = 32'(cnan);
        else if (na)       res = b;
        else if (nb)       res = a;
        else if (op == 0)  res = (xa <= xb) ? a : b;
        else               res = (xa >= xb) ? a : b;
        return {res, 1'b0, anys};
      end
      3'd2: begin c = !anyn && (ka == kb); return {31'd0, c, c, anys}; end
      3'd3: begin c = !anyn && (ka <  kb); return {31'd0, c, c, anyn}; end
      3'd4: begin c = !anyn && (ka <= kb); return {31'd0, c, c, anyn}; end
      default: return '0;
    endcase
  endfunction

  // Random operand biased toward zeros, infinities, NaNs, subnormals and near-equal values.
  function automatic logic [31:0] pick(input int ew, input int mw);
    logic [31:0] s, e, m, emaxv, msb;
    emaxv = (32'd1 << ew) - 1;
    msb   = 32'd1 << (mw - 1);
    s = 32'($urandom_range(0, 1));
    m = $urandom & ((32'd1 << mw) - 1);
    e = $urandom & emaxv;
    case ($urandom_range(0, 7))
      0: begin e = 0; m = 0; end
      1: begin e = emaxv; m = 0; end
      2: begin e = emaxv; m = m | msb; end
      3: begin e = emaxv; m = (m & ~msb) | 32'd1; end
      4: e = 0;
      5: begin e = 32'd1 << (ew - 1); m = m & 32'd3; end
      6: begin e = (32'd1 << (ew - 1)) - 1 + 32'($urandom_range(0, 1)); m = m & 32'd1; end
      default: ;
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  // One isolated op on the single-precision unit; lat counts clock edges from accept to valid.
  task automatic run_single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, output exp_t got, output int lat);
    @(negedge clk);
    s_out_ready = 1'b1; s_in_valid = 1'b1;
    s_op = op; s_a = a; s_b = b; s_tag = tag;
    #1;
    for (int t = 0; t < 20 && !s_in_ready; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = -1; got = '0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (s_out_valid) begin
        lat = k; got = {s_result, s_cmp, s_nv, s_tag_o};
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_half(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] tag, output exp_t got, output int lat);
    @(negedge clk);
    h_out_ready = 1'b1; h_in_valid = 1'b1;
    h_op = op; h_a = a; h_b = b; h_tag = tag;
    #1;
    for (int t = 0; t < 20 && !h_in_ready; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    h_in_valid = 1'b0;
    lat = -1; got = '0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (h_out_valid) begin
        lat = k; got = {16'd0, h_result, h_cmp, h_nv, h_tag_o};
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({s_out_valid, s_result, s_cmp, s_nv, s_tag_o} !== '0)
      $display("FAIL reset_sp_outputs got %h want 0", {s_out_valid, s_result, s_cmp, s_nv, s_tag_o});
    else n_pass++;
    n_checks++;
    if ({h_out_valid, h_result, h_cmp, h_nv, h_tag_o} !== '0)
      $display("FAIL reset_hp_outputs got %h want 0", {h_out_valid, h_result, h_cmp, h_nv, h_tag_o});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_in_ready !== 1'b1) $display("FAIL reset_sp_in_ready got %b want 1", s_in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    dir_t tbl [0:18];
    exp_t got, want;
    int lat;
    tbl = '{
      '{3'd2, 32'h3F800000, 32'h3F800000, 32'h1,        1'b1, 1'b0},
      '{3'd2, 32'h00000000, 32'h80000000, 32'h1,        1'b1, 1'b0},
      '{3'd2, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b0, 1'b0},
      '{3'd2, 32'h7F800001, 32'h3F800000, 32'h0,        1'b0, 1'b1},
      '{3'd3, 32'hBF800000, 32'hC0000000, 32'h0,        1'b0, 1'b0},
      '{3'd3, 32'hC0000000, 32'hBF800000, 32'h1,        1'b1, 1'b0},
      '{3'd3, 32'h3F800000, 32'h3FC00000, 32'h1,        1'b1, 1'b0},
      '{3'd4, 32'h7FC00000, 32'h3F800000, 32'h0,        1'b0, 1'b1},
      '{3'd0, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0},
      '{3'd0, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1},
      '{3'd1, 32'h7FC00000, 32'hFF800001, 32'h7FC00000, 1'b0, 1'b1},
      '{3'd0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0},
      '{3'd1, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
      '{3'd3, 32'h00000001, 32'h00800000, 32'h1,        1'b1, 1'b0},
      '{3'd3, 32'h80000001, 32'h00000000, 32'h1,        1'b1, 1'b0},
      '{3'd4, 32'h80000000, 32'h00000000, 32'h1,        1'b1, 1'b0},
      '{3'd6, 32'h7F800001, 32'h3F800000, 32'h0,        1'b0, 1'b0},
      '{3'd3, 32'h00000000, 32'h80000000, 32'h0,        1'b0, 1'b0},
      '{3'd1, 32'hFF800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0}
    };
    for (int i = 0; i < 19; i++) begin
      run_single(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), got, lat);
      want = {tbl[i].res, tbl[i].c, tbl[i].nv, 4'(i)};
      n_checks++;
      if (got !== want)
        $display("FAIL directed_%0d got res=%h cmp=%b nv=%b tag=%h want res=%h cmp=%b nv=%b tag=%h",
                 i, got.res, got.c, got.nv, got.tag, want.res, want.c, want.nv, want.tag);
      else n_pass++;
      n_checks++;
      if (lat != 2) $display("FAIL directed_latency_%0d got %0d want 2", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_half();
    exp_t got, want;
    int lat;
    logic [15:0] a, b;
    logic [2:0] op;
    run_half(3'd3, 16'h3C00, 16'h4000, 4'd1, got, lat);
    n_checks++;
    if (got !== exp_t'({32'h1, 1'b1, 1'b0, 4'd1}))
      $display("FAIL half_lt got res=%h cmp=%b nv=%b want res=1 cmp=1 nv=0", got.res, got.c, got.nv);
    else n_pass++;
    n_checks++;
    if (lat != 1) $display("FAIL half_latency got %0d want 1", lat);
    else n_pass++;
    run_half(3'd0, 16'h7E00, 16'h7E00, 4'd2, got, lat);
    n_checks++;
    if (got !== exp_t'({32'h7E00, 1'b0, 1'b0, 4'd2}))
      $display("FAIL half_min_nan got res=%h nv=%b want res=7e00 nv=0", got.res, got.nv);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'(pick(5, 10));
      b = 16'(pick(5, 10));
      run_half(op, a, b, 4'(i), got, lat);
      want = {ref_cmp(op, {16'd0, a}, {16'd0, b}, 5, 10), 4'(i)};
      n_checks++;
      if (got !== want || lat != 1)
        $display("FAIL half_rand_%0d op=%0d a=%h b=%h got %h lat %0d want %h lat 1",
                 i, op, a, b, got, lat, want);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t got, want;
    logic [38:0] snap;
    bit hold, pend;
    int sent, cyc_n;
    logic [3:0] tag;
    hold = 0; pend = 0; sent = 0; cyc_n = 0; tag = 0; snap = '0;
    while ((sent < 400 || q.size() != 0) && cyc_n < 4000) begin
      @(negedge clk);
      if (hold) begin
        n_checks++;
        if ({s_out_valid, s_result, s_cmp, s_nv, s_tag_o} !== snap)
          $display("FAIL rand_stall_stable got %h want %h", {s_out_valid, s_result, s_cmp, s_nv, s_tag_o}, snap);
        else n_pass++;
      end
      s_out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if (sent < 400 && $urandom_range(0, 4) != 0) begin
          s_in_valid = 1'b1;
          s_op = 3'($urandom_range(0, 7));
          s_a = pick(8, 23);
          s_b = pick(8, 23);
          s_tag = tag;
        end else s_in_valid = 1'b0;
      end
      #1;
      if (s_out_valid && s_out_ready) begin
        got = {s_result, s_cmp, s_nv, s_tag_o};
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_unexpected_output got %h want none", got);
        else begin
          want = q.pop_front();
          if (got !== want) $display("FAIL rand_result got %h want %h", got, want);
          else n_pass++;
        end
      end
      if (s_in_valid && s_in_ready) begin
        q.push_back({ref_cmp(s_op, s_a, s_b, 8, 23), s_tag});
        sent++; tag++; pend = 0;
      end else pend = s_in_valid;
      hold = s_out_valid && !s_out_ready;
      snap = {s_out_valid, s_result, s_cmp, s_nv, s_tag_o};
      cyc_n++;
    end
    @(negedge clk);
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    n_checks++;
    if (q.size() != 0 || sent != 400)
      $display("FAIL rand_drain got pending=%0d sent=%0d want pending=0 sent=400", q.size(), sent);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t got, want;
    logic [38:0] snap;
    int next, outs;
    next = 0; outs = 0; snap = '0;
    for (int c = 0; c < 60 && outs < 8; c++) begin
      @(negedge clk);
      s_out_ready = !(c >= 3 && c <= 5);
      if (next < 8) begin
        s_in_valid = 1'b1;
        s_op = 3'(next % 5);
        s_a = pick(8, 23);
        s_b = pick(8, 23);
        s_tag = 4'(next);
      end else s_in_valid = 1'b0;
      #1;
      if (c == 3) snap = {s_out_valid, s_result, s_cmp, s_nv, s_tag_o};
      if (c == 4) begin
        n_checks++;
        if ({s_out_valid, s_in_ready} !== 2'b10)
          $display("FAIL b2b_full_in_ready got valid=%b ready=%b want valid=1 ready=0", s_out_valid, s_in_ready);
        else n_pass++;
      end
      if (c >= 4 && c <= 6) begin
        n_checks++;
        if ({s_out_valid, s_result, s_cmp, s_nv, s_tag_o} !== snap)
          $display("FAIL b2b_stall_stable_c%0d got %h want %h", c, {s_out_valid, s_result, s_cmp, s_nv, s_tag_o}, snap);
        else n_pass++;
      end
      if (s_out_valid && s_out_ready) begin
        got = {s_result, s_cmp, s_nv, s_tag_o};
        n_checks++;
        if (q.size() == 0) $display("FAIL b2b_unexpected got %h want none", got);
        else begin
          want = q.pop_front();
          if (got !== want || got.tag != 4'(outs))
            $display("FAIL b2b_order got %h want %h", got, want);
          else n_pass++;
        end
        outs++;
      end
      if (s_in_valid && s_in_ready) begin
        q.push_back({ref_cmp(s_op, s_a, s_b, 8, 23), s_tag});
        next++;
      end
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    n_checks++;
    if (outs != 8 || q.size() != 0 || s_out_valid !== 1'b0)
      $display("FAIL b2b_count got outs=%0d pending=%0d valid=%b want 8 0 0", outs, q.size(), s_out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    exp_t got;
    int lat;
    int extra;
    @(negedge clk);
    s_out_ready = 1'b0; s_in_valid = 1'b1;
    s_op = 3'd3; s_a = 32'h3F800000; s_b = 32'h40000000; s_tag = 4'd1;
    @(negedge clk);
    s_tag = 4'd2;
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    n_checks++;
    if (s_out_valid !== 1'b1) $display("FAIL rst_mid_inflight got valid=%b want 1", s_out_valid);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_out_valid, s_result, s_cmp, s_nv, s_tag_o} !== '0)
      $display("FAIL rst_mid_cleared got %h want 0", {s_out_valid, s_result, s_cmp, s_nv, s_tag_o});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_out_ready = 1'b1;
    run_single(3'd1, 32'h3F800000, 32'hBF800000, 4'd9, got, lat);
    n_checks++;
    if (got !== exp_t'({32'h3F800000, 1'b0, 1'b0, 4'd9}) || lat != 2)
      $display("FAIL rst_mid_first_after got %h lat %0d want tag 9 res 3f800000 lat 2", got, lat);
    else n_pass++;
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (s_out_valid) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL rst_mid_no_ghosts got %0d extra outputs want 0", extra);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_half();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
